// File: rtl/queue_sensor_frontend_pkg.sv
// Shared types and helpers for the bank-queue sensor front end.
package queue_sensor_frontend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PULSE_UP   = 2'd1,
    ST_PULSE_DOWN = 2'd2,
    ST_GAP        = 2'd3
  } fe_state_e;

  localparam int NUM_SENSORS = 2;
  localparam int LANE_UP     = 0;  // front photocell feeds the up lane
  localparam int LANE_DN     = 1;  // back photocell feeds the down lane

  // Width able to hold 0..max(a,b)-1, never narrower than one bit.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/queue_sensor_frontend_debounce.sv
// One photocell channel: synchroniser chain, debounce counter and 0->1 event strobe.
module sensor_debounce
  import queue_sensor_frontend_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = timer_w(DEBOUNCE_CYCLES, 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_i,
  output logic event_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_stable_d;
  logic                   r_event;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign event_o  = r_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_event    <= 1'b0;
    end else begin
      r_sync[0] <= sensor_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_stable_d <= r_stable;
      r_event    <= r_stable & ~r_stable_d;
      // Any sample agreeing with the accepted level restarts the qualification window.
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= w_synced;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_sensor_frontend.sv
// Bank-queue front end: debounced entry/exit events become serialised up/down strobes
// with guard gaps; events the counter cannot legally take are dropped.
module queue_sensor_frontend
  import queue_sensor_frontend_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int PEND_W          = 2,
  parameter int COUNT_W         = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               front_sensor_i,
  input  logic               back_sensor_i,
  input  logic [COUNT_W-1:0] queue_count_i,
  output logic               up_o,
  output logic               down_o,
  output logic               drop_o,
  output logic               busy_o
);

  localparam int                 TMR_W      = timer_w(DEBOUNCE_CYCLES, PULSE_CYCLES);
  localparam logic [PEND_W-1:0]  PEND_MAX   = '1;
  localparam logic [COUNT_W-1:0] COUNT_FULL = '1;
  localparam logic [TMR_W-1:0]   PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);

  logic [NUM_SENSORS-1:0]             w_sensor;
  logic [NUM_SENSORS-1:0]             w_event;
  logic [NUM_SENSORS-1:0]             w_inc;
  logic [NUM_SENSORS-1:0]             w_dec;
  logic [NUM_SENSORS-1:0]             w_launch;
  logic [NUM_SENSORS-1:0]             w_discard;
  logic [NUM_SENSORS-1:0]             w_sat;
  logic [NUM_SENSORS-1:0][PEND_W-1:0] r_pend;
  logic [NUM_SENSORS-1:0][PEND_W-1:0] w_pend_nxt;

  fe_state_e        r_state, w_state_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic             r_up, r_down, r_drop;

  assign w_sensor[LANE_UP] = front_sensor_i;
  assign w_sensor[LANE_DN] = back_sensor_i;

  generate
    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sns
      sensor_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (TMR_W)
      ) u_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .sensor_i(w_sensor[g]),
        .event_o (w_event[g])
      );
    end
  endgenerate

  // A person entering and one leaving in the same cycle leaves occupancy unchanged.
  assign w_inc[LANE_UP] = w_event[LANE_UP] & ~w_event[LANE_DN];
  assign w_inc[LANE_DN] = w_event[LANE_DN] & ~w_event[LANE_UP];
  assign w_dec          = w_launch | w_discard;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_launch    = '0;
    w_discard   = '0;
    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt = '0;
        if (r_pend[LANE_DN] != '0) begin
          if (queue_count_i == '0) begin
            w_discard[LANE_DN] = 1'b1;
          end else begin
            w_launch[LANE_DN] = 1'b1;
            w_state_nxt       = ST_PULSE_DOWN;
          end
        end else if (r_pend[LANE_UP] != '0) begin
          if (queue_count_i == COUNT_FULL) begin
            w_discard[LANE_UP] = 1'b1;
          end else begin
            w_launch[LANE_UP] = 1'b1;
            w_state_nxt       = ST_PULSE_UP;
          end
        end
      end
      ST_PULSE_UP, ST_PULSE_DOWN, ST_GAP: begin
        if (r_tmr == PULSE_LAST) begin
          w_tmr_nxt   = '0;
          w_state_nxt = (r_state == ST_GAP) ? ST_IDLE : ST_GAP;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pend_nxt = r_pend;
    w_sat      = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (w_inc[i] && !w_dec[i]) begin
        if (r_pend[i] == PEND_MAX) w_sat[i] = 1'b1;
        else                       w_pend_nxt[i] = r_pend[i] + 1'b1;
      end else if (!w_inc[i] && w_dec[i]) begin
        w_pend_nxt[i] = r_pend[i] - 1'b1;
      end
    end
  end

  // Strobes are decoded from the next state so they leave a flop and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_pend  <= '0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_pend  <= w_pend_nxt;
      r_up    <= (w_state_nxt == ST_PULSE_UP);
      r_down  <= (w_state_nxt == ST_PULSE_DOWN);
      r_drop  <= (|w_sat) | (|w_discard);
    end
  end

  assign up_o   = r_up;
  assign down_o = r_down;
  assign drop_o = r_drop;
  assign busy_o = (r_state != ST_IDLE) | (|r_pend);

endmodule
